instr_rom_loader: RTL and testbench

- Field-level instruction encoder and instruction-ROM writer. It is the write-side counterpart of the instruction decoder.
- Accepts one instruction per handshake as separate fields (format, opcode, rs, rt, shamt, fcode, imm, label) and packs them into the 32-bit KGP-RISC word.
- Writes the words into sequential instruction-memory addresses, with optional read-back verification.
- Sits between the bench/boot source and the instruction memory; drives the memory write port in place of the processor during program load.

---
 rtl/kgp_risc_pkg.sv | 55 +++++
 rtl/instr_encode.sv | 41 ++++
 rtl/instr_rom_loader.sv | 167 ++++++++++++++++
 tb/tb_instr_rom_loader.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kgp_risc_pkg.sv
// KGP-RISC shared definitions: instruction formats, field positions, loader states.
// Used by the ROM loader and the instruction decoder.
package kgp_risc_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        FMT_R = 2'b00,
        FMT_I = 2'b01,
        FMT_J = 2'b10,
        FMT_X = 2'b11
    } fmt_e;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 29;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

    localparam int RS_MSB  = 28;
    localparam int RS_LSB  = 24;
    localparam int RS_W    = RS_MSB - RS_LSB + 1;

    localparam int RT_MSB  = 23;
    localparam int RT_LSB  = 19;
    localparam int RT_W    = RT_MSB - RT_LSB + 1;

    localparam int SH_MSB  = 18;
    localparam int SH_LSB  = 14;
    localparam int SH_W    = SH_MSB - SH_LSB + 1;

    localparam int FC_MSB  = 3;
    localparam int FC_LSB  = 0;
    localparam int FC_W    = FC_MSB - FC_LSB + 1;

    localparam int IMM_MSB = 21;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;

    localparam int LBL_MSB = 24;
    localparam int LBL_LSB = 0;
    localparam int LBL_W   = LBL_MSB - LBL_LSB + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_WRITE,
        ST_RD,
        ST_CHECK,
        ST_DONE
    } ld_state_e;

    function automatic logic fmt_legal(input logic [1:0] f);
        return fmt_e'(f) != FMT_X;
    endfunction

endpackage

// File: rtl/instr_encode.sv
// Combinational field packer: format + fields -> 32-bit KGP-RISC word.
// Unused fields are ignored; fmt 11 flags illegal.
module instr_encode (
    input  logic [1:0]  fmt_i,
    input  logic [2:0]  opcode_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  shamt_i,
    input  logic [3:0]  fcode_i,
    input  logic [21:0] imm_i,
    input  logic [24:0] label_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);
    import kgp_risc_pkg::*;

    always_comb begin
        word_o    = '0;
        illegal_o = !fmt_legal(fmt_i);
        word_o[OPC_MSB:OPC_LSB] = opcode_i;
        unique case (fmt_e'(fmt_i))
            FMT_R: begin
                word_o[RS_MSB:RS_LSB] = rs_i;
                word_o[RT_MSB:RT_LSB] = rt_i;
                word_o[SH_MSB:SH_LSB] = shamt_i;
                word_o[FC_MSB:FC_LSB] = fcode_i;
            end
            FMT_I: begin
                word_o[RS_MSB:RS_LSB]   = rs_i;
                word_o[IMM_MSB:IMM_LSB] = imm_i;
            end
            FMT_J: begin
                word_o[LBL_MSB:LBL_LSB] = label_i;
            end
            FMT_X: begin
                word_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/instr_rom_loader.sv
// Program loader: encodes field bundles and writes them to sequential
// instruction-memory addresses, optionally reading each word back to verify.
module instr_rom_loader #(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0,
    parameter int VERIFY    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [2:0]        opcode,
    input  logic [4:0]        rs_addr,
    input  logic [4:0]        rt_addr,
    input  logic [4:0]        shamt,
    input  logic [3:0]        fcode,
    input  logic [21:0]       imm,
    input  logic [24:0]       label,
    input  logic              last,
    output logic              rom_we,
    output logic              rom_re,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [31:0]       rom_wdata,
    input  logic [31:0]       rom_rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mismatch,
    output logic [ADDR_W:0]   count
);
    import kgp_risc_pkg::*;

    localparam int LAST_I = BASE_ADDR + DEPTH - 1;
    localparam logic [ADDR_W-1:0] BASE = BASE_ADDR[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] LAST = LAST_I[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] A_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   C_ONE = {{ADDR_W{1'b0}}, 1'b1};

    ld_state_e         state_q;
    logic              rom_we_q;
    logic              rom_re_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W:0]   count_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              mis_q;
    logic              last_q;

    logic [31:0]       word_d;
    logic              illegal_d;
    logic              adv_d;

    instr_encode u_enc (
        .fmt_i     (fmt),
        .opcode_i  (opcode),
        .rs_i      (rs_addr),
        .rt_i      (rt_addr),
        .shamt_i   (shamt),
        .fcode_i   (fcode),
        .imm_i     (imm),
        .label_i   (label),
        .word_o    (word_d),
        .illegal_o (illegal_d)
    );

    // Advance happens after the write without verify, or after the compare.
    assign adv_d = (state_q == ST_CHECK) ||
                   ((state_q == ST_WRITE) && (VERIFY == 0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            rom_we_q <= 1'b0;
            rom_re_q <= 1'b0;
            addr_q   <= BASE;
            wdata_q  <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            mis_q    <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        addr_q  <= BASE;
                        count_q <= '0;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        mis_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_ACCEPT;
                    end
                end
                ST_ACCEPT: begin
                    if (in_valid) begin
                        wdata_q <= word_d;
                        last_q  <= last;
                        if (illegal_d) begin
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            rom_we_q <= 1'b1;
                            state_q  <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    rom_we_q <= 1'b0;
                    count_q  <= count_q + C_ONE;
                    if (VERIFY != 0) begin
                        rom_re_q <= 1'b1;
                        state_q  <= ST_RD;
                    end
                end
                ST_RD: begin
                    rom_re_q <= 1'b0;
                    state_q  <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (rom_rdata != wdata_q) begin
                        mis_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            if (adv_d) begin
                if (last_q) begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end else if (addr_q == LAST) begin
                    err_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end else begin
                    addr_q  <= addr_q + A_ONE;
                    state_q <= ST_ACCEPT;
                end
            end
        end
    end

    assign in_ready  = (state_q == ST_ACCEPT);
    assign rom_we    = rom_we_q;
    assign rom_re    = rom_re_q;
    assign rom_addr  = addr_q;
    assign rom_wdata = wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign mismatch  = mis_q;
    assign count     = count_q;

endmodule

// File: tb/tb_instr_rom_loader.sv
// Bench for instr_rom_loader: two instances (verify / no-verify, small depth)
// checked against a session-level reference model and an encoding table.
module tb_instr_rom_loader;

    typedef struct {
        logic [1:0]  fmt;
        logic [2:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  sh;
        logic [3:0]  fc;
        logic [21:0] imm;
        logic [24:0] lbl;
        logic        last;
    } bundle_t;

    typedef struct {
        bundle_t     b;
        logic [31:0] word;
        int          nw;
        logic        err;
    } vec_t;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int sel     = 0;

    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  f_fmt = '0;
    logic [2:0]  f_op = '0;
    logic [4:0]  f_rs = '0;
    logic [4:0]  f_rt = '0;
    logic [4:0]  f_sh = '0;
    logic [3:0]  f_fc = '0;
    logic [21:0] f_imm = '0;
    logic [24:0] f_lbl = '0;
    logic        f_last = 1'b0;

    logic start_a, start_b, iv_a, iv_b;
    assign start_a = start && (sel == 0);
    assign start_b = start && (sel == 1);
    assign iv_a    = in_valid && (sel == 0);
    assign iv_b    = in_valid && (sel == 1);

    logic        rdy_a, we_a, re_a, busy_a, done_a, err_a, mis_a;
    logic [7:0]  addr_a;
    logic [31:0] wdata_a;
    logic [31:0] rdata_a = '0;
    logic [8:0]  count_a;
    logic        rdy_b, we_b, re_b, busy_b, done_b, err_b, mis_b;
    logic [7:0]  addr_b;
    logic [31:0] wdata_b;
    logic [31:0] rdata_b = '0;
    logic [8:0]  count_b;

    instr_rom_loader #(.ADDR_W(8), .DEPTH(256), .BASE_ADDR(0), .VERIFY(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .in_valid(iv_a), .in_ready(rdy_a),
        .fmt(f_fmt), .opcode(f_op), .rs_addr(f_rs), .rt_addr(f_rt), .shamt(f_sh),
        .fcode(f_fc), .imm(f_imm), .label(f_lbl), .last(f_last),
        .rom_we(we_a), .rom_re(re_a), .rom_addr(addr_a), .rom_wdata(wdata_a),
        .rom_rdata(rdata_a), .busy(busy_a), .done(done_a), .err(err_a),
        .mismatch(mis_a), .count(count_a)
    );

    instr_rom_loader #(.ADDR_W(8), .DEPTH(4), .BASE_ADDR(8), .VERIFY(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .in_valid(iv_b), .in_ready(rdy_b),
        .fmt(f_fmt), .opcode(f_op), .rs_addr(f_rs), .rt_addr(f_rt), .shamt(f_sh),
        .fcode(f_fc), .imm(f_imm), .label(f_lbl), .last(f_last),
        .rom_we(we_b), .rom_re(re_b), .rom_addr(addr_b), .rom_wdata(wdata_b),
        .rom_rdata(rdata_b), .busy(busy_b), .done(done_b), .err(err_b),
        .mismatch(mis_b), .count(count_b)
    );

    logic       cur_ready, cur_done, cur_err, cur_mis, cur_busy;
    logic [8:0] cur_count;
    assign cur_ready = sel ? rdy_b   : rdy_a;
    assign cur_done  = sel ? done_b  : done_a;
    assign cur_err   = sel ? err_b   : err_a;
    assign cur_mis   = sel ? mis_b   : mis_a;
    assign cur_busy  = sel ? busy_b  : busy_a;
    assign cur_count = sel ? count_b : count_a;

    // Instruction memories; A can corrupt bit 0 on read-back of one address.
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic        corrupt_en = 1'b0;
    logic [7:0]  corrupt_addr = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (we_a) mem_a[addr_a] <= wdata_a;
        if (re_a) rdata_a <= mem_a[addr_a] ^ {31'd0, corrupt_en && (addr_a == corrupt_addr)};
        if (we_b) mem_b[addr_b] <= wdata_b;
        if (re_b) rdata_b <= mem_b[addr_b];
    end

    wr_t wq[$];
    always @(negedge clk) begin
        if (we_a) wq.push_back('{int'(addr_a), wdata_a});
        if (we_b) wq.push_back('{int'(addr_b), wdata_b});
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bundle_t mk(input logic [1:0] fmt, input logic [2:0] op,
                                   input logic [4:0] rs, input logic [4:0] rt,
                                   input logic [4:0] sh, input logic [3:0] fc,
                                   input logic [21:0] imm, input logic [24:0] lbl,
                                   input logic last);
        bundle_t b;
        b.fmt = fmt; b.op = op; b.rs = rs; b.rt = rt; b.sh = sh;
        b.fc = fc; b.imm = imm; b.lbl = lbl; b.last = last;
        return b;
    endfunction

    function automatic bundle_t rnd_bundle(input logic last);
        bundle_t b;
        b.fmt  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        b.op   = 3'($urandom);
        b.rs   = 5'($urandom);
        b.rt   = 5'($urandom);
        b.sh   = 5'($urandom);
        b.fc   = 4'($urandom);
        b.imm  = 22'($urandom);
        b.lbl  = 25'($urandom);
        b.last = last;
        return b;
    endfunction

    // Reference encoding by arithmetic on the field values.
    function automatic logic [31:0] ref_enc(input bundle_t b);
        logic [31:0] w;
        w = 32'(b.op) * 32'h2000_0000;
        case (b.fmt)
            2'b00: w = w + 32'(b.rs) * 32'h0100_0000 + 32'(b.rt) * 32'h0008_0000
                         + 32'(b.sh) * 32'h0000_4000 + 32'(b.fc);
            2'b01: w = w + 32'(b.rs) * 32'h0100_0000 + 32'(b.imm);
            2'b10: w = w + 32'(b.lbl);
            default: w = w;
        endcase
        return w;
    endfunction

    task automatic drive(input bundle_t b);
        f_fmt = b.fmt; f_op = b.op; f_rs = b.rs; f_rt = b.rt; f_sh = b.sh;
        f_fc = b.fc; f_imm = b.imm; f_lbl = b.lbl; f_last = b.last;
    endtask

    bundle_t bq[$];
    int      acc_cyc[$];

    task automatic run_session(input int s, input int corrupt_idx, input string tag);
        wr_t  exp[$];
        int   base, depth, verify, naccept;
        logic eerr, emis;
        base   = s ? 8 : 0;
        depth  = s ? 4 : 256;
        verify = s ? 0 : 1;
        eerr = 1'b0; emis = 1'b0; naccept = 0;
        foreach (bq[i]) begin
            naccept++;
            if (bq[i].fmt == 2'b11) begin eerr = 1'b1; break; end
            exp.push_back('{base + i, ref_enc(bq[i])});
            if (verify == 1 && i == corrupt_idx) emis = 1'b1;
            if (bq[i].last) break;
            if (i == depth - 1) begin eerr = 1'b1; break; end
        end

        sel = s;
        wq.delete();
        acc_cyc.delete();
        corrupt_en   = (corrupt_idx >= 0);
        corrupt_addr = 8'(base + corrupt_idx);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        foreach (bq[i]) begin
            bit ok, fin;
            ok = 0; fin = 0;
            drive(bq[i]);
            in_valid = 1'b1;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (cur_ready) begin ok = 1; break; end
                if (cur_done) begin fin = 1; break; end
            end
            if (ok) begin
                acc_cyc.push_back(cyc);
                @(posedge clk); #1 in_valid = 1'b0;
            end else begin
                in_valid = 1'b0;
                if (!fin) chk({tag, "_accept_timeout"}, 0, 1);
                break;
            end
        end
        in_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (cur_done) break;
        end
        chk({tag, "_done"}, cur_done, 1);
        chk({tag, "_busy"}, cur_busy, 0);
        chk({tag, "_ready"}, cur_ready, 0);
        chk({tag, "_err"}, cur_err, eerr);
        chk({tag, "_mismatch"}, cur_mis, emis);
        chk({tag, "_count"}, cur_count, exp.size());
        chk({tag, "_accepts"}, acc_cyc.size(), naccept);
        chk({tag, "_nwrites"}, wq.size(), exp.size());
        for (int i = 0; i < exp.size() && i < wq.size(); i++) begin
            chk({tag, "_waddr"}, wq[i].addr, exp[i].addr);
            chk({tag, "_wdata"}, wq[i].data, exp[i].data);
        end
        for (int i = 1; i < acc_cyc.size(); i++)
            chk({tag, "_gap"}, acc_cyc[i] - acc_cyc[i-1], verify ? 4 : 2);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_a_ready"}, rdy_a, 0);
        chk({tag, "_a_we"}, we_a, 0);
        chk({tag, "_a_re"}, re_a, 0);
        chk({tag, "_a_busy"}, busy_a, 0);
        chk({tag, "_a_done"}, done_a, 0);
        chk({tag, "_a_err"}, err_a, 0);
        chk({tag, "_a_mis"}, mis_a, 0);
        chk({tag, "_a_addr"}, addr_a, 0);
        chk({tag, "_a_wdata"}, wdata_a, 0);
        chk({tag, "_a_count"}, count_a, 0);
        chk({tag, "_b_we"}, we_b, 0);
        chk({tag, "_b_done"}, done_b, 0);
        chk({tag, "_b_addr"}, addr_b, 8);
        chk({tag, "_b_count"}, count_b, 0);
    endtask

    vec_t tbl[7];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{mk(2'b00, 3'd0, 5'd2,  5'd3,  5'd0,  4'h5, 22'h0,      25'h0,       1'b1), 32'h0218_0005, 1, 1'b0};
        tbl[1] = '{mk(2'b01, 3'd2, 5'd1,  5'd0,  5'd0,  4'h0, 22'h3FFFFF, 25'h0,       1'b1), 32'h413F_FFFF, 1, 1'b0};
        tbl[2] = '{mk(2'b10, 3'd4, 5'd0,  5'd0,  5'd0,  4'h0, 22'h0,      25'h1ABCDEF, 1'b1), 32'h81AB_CDEF, 1, 1'b0};
        tbl[3] = '{mk(2'b00, 3'd7, 5'd31, 5'd31, 5'd31, 4'hF, 22'h3FFFFF, 25'h1FFFFFF, 1'b1), 32'hFFFF_C00F, 1, 1'b0};
        tbl[4] = '{mk(2'b01, 3'd3, 5'h15, 5'd31, 5'd31, 4'hF, 22'h123456, 25'h1FFFFFF, 1'b1), 32'h7512_3456, 1, 1'b0};
        tbl[5] = '{mk(2'b10, 3'd7, 5'd31, 5'd31, 5'd31, 4'hF, 22'h3FFFFF, 25'h1FFFFFF, 1'b1), 32'hE1FF_FFFF, 1, 1'b0};
        tbl[6] = '{mk(2'b11, 3'd5, 5'd1,  5'd2,  5'd3,  4'h4, 22'h5,      25'h6,       1'b1), 32'h0,         0, 1'b1};

        repeat (3) @(posedge clk);
        #1 chk_reset_outputs("reset");
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            bq.delete();
            bq.push_back(tbl[i].b);
            run_session(0, -1, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_nw", i), wq.size(), tbl[i].nw);
            chk($sformatf("tbl%0d_errv", i), err_a, tbl[i].err);
            if (tbl[i].nw > 0 && wq.size() > 0)
                chk($sformatf("tbl%0d_word", i), wq[0].data, tbl[i].word);
        end

        // I-type then J-type back to back
        bq.delete();
        bq.push_back(mk(2'b01, 3'd2, 5'd1, 5'd0, 5'd0, 4'h0, 22'h3FFFFF, 25'h0, 1'b0));
        bq.push_back(mk(2'b10, 3'd4, 5'd0, 5'd0, 5'd0, 4'h0, 22'h0, 25'h1ABCDEF, 1'b1));
        run_session(0, -1, "ij");
        if (acc_cyc.size() == 2) chk("ij_gap4", acc_cyc[1] - acc_cyc[0], 4);

        // read-back corruption on word 0, session continues
        bq.delete();
        for (int i = 0; i < 3; i++) bq.push_back(rnd_bundle(i == 2));
        foreach (bq[i]) if (bq[i].fmt == 2'b11) bq[i].fmt = 2'b00;
        run_session(0, 0, "verify");
        chk("verify_mis_set", mis_a, 1);

        // overflow on the four-deep instance, fifth bundle refused
        bq.delete();
        for (int i = 0; i < 5; i++) bq.push_back(mk(2'b00, 3'(i), 5'(i), 5'd1, 5'd2, 4'(i), 22'h0, 25'h0, 1'b0));
        run_session(1, -1, "ovf");
        chk("ovf_err", err_b, 1);
        chk("ovf_count", count_b, 4);

        // last wins over overflow on the final slot
        bq.delete();
        for (int i = 0; i < 4; i++) bq.push_back(mk(2'b10, 3'd1, 5'd0, 5'd0, 5'd0, 4'h0, 22'h0, 25'(i), i == 3));
        run_session(1, -1, "lastwins");
        chk("lastwins_err", err_b, 0);

        // illegal format on the second bundle
        bq.delete();
        bq.push_back(mk(2'b00, 3'd1, 5'd4, 5'd5, 5'd6, 4'h7, 22'h0, 25'h0, 1'b0));
        bq.push_back(mk(2'b11, 3'd1, 5'd4, 5'd5, 5'd6, 4'h7, 22'h0, 25'h0, 1'b0));
        bq.push_back(mk(2'b00, 3'd1, 5'd4, 5'd5, 5'd6, 4'h7, 22'h0, 25'h0, 1'b1));
        run_session(0, -1, "illegal");
        chk("illegal_count", count_a, 1);

        // reset during the write cycle
        sel = 0;
        corrupt_en = 1'b0;
        wq.delete();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        drive(mk(2'b00, 3'd6, 5'd9, 5'd9, 5'd9, 4'h9, 22'h0, 25'h0, 1'b0));
        in_valid = 1'b1;
        begin
            bit seen;
            seen = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (rdy_a) begin seen = 1; break; end
            end
            chk("rst_mid_ready", seen, 1);
        end
        @(posedge clk); #1 in_valid = 1'b0;
        chk("rst_mid_we_before", we_a, 1);
        rst = 1'b0;
        #1 chk_reset_outputs("rst_mid");
        @(posedge clk); #1 rst = 1'b1;
        chk("rst_mid_nwrites", wq.size(), 0);
        bq.delete();
        bq.push_back(mk(2'b01, 3'd5, 5'd7, 5'd0, 5'd0, 4'h0, 22'h2AAAAA, 25'h0, 1'b1));
        run_session(0, -1, "after_rst");

        // randomized sessions on both instances
        for (int t = 0; t < 30; t++) begin
            int s, n, cidx;
            s = $urandom_range(0, 1);
            n = $urandom_range(1, 6);
            bq.delete();
            for (int i = 0; i < n; i++) begin
                logic l;
                if (i == n - 1) l = (s == 1 && n >= 5) ? 1'($urandom) : 1'b1;
                else l = ($urandom_range(0, 7) == 0);
                bq.push_back(rnd_bundle(l));
            end
            cidx = (s == 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
            run_session(s, cidx, $sformatf("rnd%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
